tank_bullet_ctrl: RTL and testbench

Downstream consumer of the tank movement stage. Takes the tank's top-left position and direction keys, tracks facing, launches one bullet per fire press, and moves it once per frame. Ends flight on border exit or collision. Outputs bullet position and active flag to the bullet drawer, and a launch pulse (wasShoot) back to the tank movement stage.

---
 rtl/tank_bullet_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_tank_bullet_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tank_bullet_ctrl.sv
// rtl/tank_bullet_ctrl.sv - single-bullet launcher, mover and lifetime controller for the tank
// Optional feature macro: BULLET_AUTOFIRE_EN (held fire key relaunches on every return to IDLE)
module tank_bullet_ctrl #(
  parameter int TANK_SIZE       = 32,
  parameter int BULLET_SIZE     = 4,
  parameter int SPEED           = 8,
  parameter int COOLDOWN_FRAMES = 15,
  parameter int X_MAX           = 639,
  parameter int Y_MAX           = 479
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        fire,
  input  logic        up_direction,
  input  logic        down_direction,
  input  logic        right_direction,
  input  logic        left_direction,
  input  logic [10:0] tankTopLeftX,
  input  logic [10:0] tankTopLeftY,
  input  logic        collision,
  output logic [10:0] bulletTopLeftX,
  output logic [10:0] bulletTopLeftY,
  output logic        bulletActive,
  output logic        wasShoot,
  output logic        hitPulse
);

  typedef enum logic [1:0] {IDLE, FLYING, COOLDOWN} state_t;
  typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

  localparam int CW = $clog2(COOLDOWN_FRAMES + 2);

  // All geometry is done in 12-bit signed so that off-frame positions show up as negatives
  localparam logic signed [11:0] OFS  = 12'((TANK_SIZE - BULLET_SIZE) / 2);
  localparam logic signed [11:0] TS12 = 12'(TANK_SIZE);
  localparam logic signed [11:0] BS12 = 12'(BULLET_SIZE);
  localparam logic signed [11:0] SP12 = 12'(SPEED);
  localparam logic signed [11:0] XM12 = 12'(X_MAX);
  localparam logic signed [11:0] YM12 = 12'(Y_MAX);

  state_t            state;
  dir_t              facing;
  dir_t              bullet_dir;
  logic              fire_d;
  logic              pending;
  logic [CW-1:0]     cd_cnt;

  logic              fire_rise;
  logic              pend_set;
  logic [3:0]        keys;
  logic signed [11:0] tx, ty, cx, cy;
  logic signed [11:0] sx, sy, nx, ny;
  logic              spawn_oob;
  logic              next_oob;

  // True when any part of a bullet placed at (x,y) would fall outside the visible frame
  function automatic logic off_frame(input logic signed [11:0] x, input logic signed [11:0] y);
    off_frame = (x < 12'sd0) || (y < 12'sd0) ||
                ((x + BS12 - 12'sd1) > XM12) || ((y + BS12 - 12'sd1) > YM12);
  endfunction

  assign fire_rise = fire & ~fire_d;
`ifdef BULLET_AUTOFIRE_EN
  assign pend_set  = fire;
`else
  assign pend_set  = fire_rise;
`endif

  assign keys = {up_direction, down_direction, left_direction, right_direction};
  assign tx   = $signed({1'b0, tankTopLeftX});
  assign ty   = $signed({1'b0, tankTopLeftY});
  assign cx   = $signed({1'b0, bulletTopLeftX});
  assign cy   = $signed({1'b0, bulletTopLeftY});

  // Spawn point: centred on the tank edge the tank is facing, just outside the sprite
  always_comb begin
    sx = tx + OFS;
    sy = ty - BS12;
    case (facing)
      DIR_DOWN:  sy = ty + TS12;
      DIR_LEFT:  begin sx = tx - BS12; sy = ty + OFS; end
      DIR_RIGHT: begin sx = tx + TS12; sy = ty + OFS; end
      default:   ;
    endcase
    spawn_oob = off_frame(sx, sy);
  end

  // Candidate position one frame ahead along the latched bullet direction
  always_comb begin
    nx = cx;
    ny = cy;
    case (bullet_dir)
      DIR_UP:    ny = cy - SP12;
      DIR_DOWN:  ny = cy + SP12;
      DIR_LEFT:  nx = cx - SP12;
      DIR_RIGHT: nx = cx + SP12;
      default:   ;
    endcase
    next_oob = off_frame(nx, ny);
  end

  // Facing follows a single unambiguous key; fire is delayed one cycle for edge detection
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      facing <= DIR_UP;
      fire_d <= 1'b0;
    end else begin
      fire_d <= fire;
      case (keys)
        4'b1000: facing <= DIR_UP;
        4'b0100: facing <= DIR_DOWN;
        4'b0010: facing <= DIR_LEFT;
        4'b0001: facing <= DIR_RIGHT;
        default: ;
      endcase
    end
  end

  // Bullet lifetime FSM with registered position, active flag and event pulses
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state          <= IDLE;
      bullet_dir     <= DIR_UP;
      pending        <= 1'b0;
      cd_cnt         <= '0;
      bulletTopLeftX <= '0;
      bulletTopLeftY <= '0;
      bulletActive   <= 1'b0;
      wasShoot       <= 1'b0;
      hitPulse       <= 1'b0;
    end else begin
      wasShoot <= 1'b0;
      hitPulse <= 1'b0;
      case (state)
        IDLE: begin
          if (startOfFrame && pending) begin
            // A launch attempt always consumes the request, even when the spawn is off-frame
            pending <= 1'b0;
            if (!spawn_oob) begin
              bulletTopLeftX <= sx[10:0];
              bulletTopLeftY <= sy[10:0];
              bullet_dir     <= facing;
              bulletActive   <= 1'b1;
              wasShoot       <= 1'b1;
              state          <= FLYING;
            end
          end else if (pend_set) begin
            pending <= 1'b1;
          end
        end
        FLYING: begin
          if (collision) begin
            // Collision takes priority over a move in the same cycle
            hitPulse     <= 1'b1;
            bulletActive <= 1'b0;
            cd_cnt       <= CW'(COOLDOWN_FRAMES);
            state        <= COOLDOWN;
          end else if (startOfFrame) begin
            if (next_oob) begin
              bulletActive <= 1'b0;
              cd_cnt       <= CW'(COOLDOWN_FRAMES);
              state        <= COOLDOWN;
            end else begin
              bulletTopLeftX <= nx[10:0];
              bulletTopLeftY <= ny[10:0];
            end
          end
        end
        COOLDOWN: begin
          if (cd_cnt == '0) begin
            state <= IDLE;
          end else if (startOfFrame) begin
            cd_cnt <= cd_cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tank_bullet_ctrl.sv
// tb/tb_tank_bullet_ctrl.sv - scoreboard bench for tank_bullet_ctrl
module tb_tank_bullet_ctrl;

  logic        clk = 1'b0;
  logic        resetN;
  logic        startOfFrame;
  logic        fire;
  logic        up_direction;
  logic        down_direction;
  logic        right_direction;
  logic        left_direction;
  logic [10:0] tankTopLeftX;
  logic [10:0] tankTopLeftY;
  logic        collision;
  logic [10:0] bulletTopLeftX;
  logic [10:0] bulletTopLeftY;
  logic        bulletActive;
  logic        wasShoot;
  logic        hitPulse;

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic        a;
    logic        w;
    logic        h;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp  = 0;
  int  n_fail = 0;
  logic mon_en = 1'b0;

  logic [10:0] prev_x = '0;
  logic [10:0] prev_y = '0;
  logic        prev_a = 1'b0;

  tank_bullet_ctrl dut (
    .clk             (clk),
    .resetN          (resetN),
    .startOfFrame    (startOfFrame),
    .fire            (fire),
    .up_direction    (up_direction),
    .down_direction  (down_direction),
    .right_direction (right_direction),
    .left_direction  (left_direction),
    .tankTopLeftX    (tankTopLeftX),
    .tankTopLeftY    (tankTopLeftY),
    .collision       (collision),
    .bulletTopLeftX  (bulletTopLeftX),
    .bulletTopLeftY  (bulletTopLeftY),
    .bulletActive    (bulletActive),
    .wasShoot        (wasShoot),
    .hitPulse        (hitPulse)
  );

  always #5 clk = ~clk;

  // Monitor: every observable output event pops one expected record
  always @(negedge clk) begin
    ev_t act;
    ev_t e;
    if (mon_en) begin
      act = {bulletTopLeftX, bulletTopLeftY, bulletActive, wasShoot, hitPulse};
      if (wasShoot || hitPulse || (bulletActive != prev_a) ||
          (bulletActive && ((bulletTopLeftX != prev_x) || (bulletTopLeftY != prev_y)))) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_event: got x=%0d y=%0d act=%0d shoot=%0d hit=%0d, expected no event",
                   act.x, act.y, act.a, act.w, act.h);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            n_fail++;
            $display("FAIL event: got x=%0d y=%0d act=%0d shoot=%0d hit=%0d, expected x=%0d y=%0d act=%0d shoot=%0d hit=%0d",
                     act.x, act.y, act.a, act.w, act.h, e.x, e.y, e.a, e.w, e.h);
          end
        end
      end
    end
    prev_x = bulletTopLeftX;
    prev_y = bulletTopLeftY;
    prev_a = bulletActive;
  end

  task automatic expect_ev(input int x, input int y, input int a, input int w, input int h);
    exp_q.push_back({11'(x), 11'(y), 1'(a), 1'(w), 1'(h)});
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    repeat (3) tick();
  endtask

  task automatic fire_pulse();
    fire = 1'b1;
    tick();
    fire = 1'b0;
    tick();
  endtask

  task automatic hit_now(input int x, input int y);
    expect_ev(x, y, 0, 0, 1);
    collision = 1'b1;
    tick();
    collision = 1'b0;
    tick();
  endtask

  // Fifteen cooldown frames, each preceded by a fire press that must be ignored
  task automatic cooldown_fire();
    repeat (15) begin
      fire_pulse();
      frame();
    end
  endtask

  initial begin
    resetN = 1'b1;
    startOfFrame = 1'b0;
    fire = 1'b0;
    up_direction = 1'b0;
    down_direction = 1'b0;
    right_direction = 1'b0;
    left_direction = 1'b0;
    tankTopLeftX = 11'd280;
    tankTopLeftY = 11'd185;
    collision = 1'b0;

    #3 resetN = 1'b0;
    #4;
    chk("reset_x", bulletTopLeftX, 0);
    chk("reset_y", bulletTopLeftY, 0);
    chk("reset_active", bulletActive, 0);
    chk("reset_shoot", wasShoot, 0);
    chk("reset_hit", hitPulse, 0);
    tick();
    resetN = 1'b1;
    mon_en = 1'b1;
    tick();

    // Upward flight to the top border
    fire_pulse();
    expect_ev(294, 181, 1, 1, 0);
    frame();
    for (int k = 1; k <= 22; k++) begin
      expect_ev(294, 181 - 8 * k, 1, 0, 0);
      frame();
    end
    expect_ev(294, 5, 0, 0, 0);
    frame();
    cooldown_fire();

    // Rightward launch, collision, cooldown ignores fire, then relaunch
    right_direction = 1'b1;
    tick();
    fire_pulse();
    expect_ev(312, 199, 1, 1, 0);
    frame();
    for (int k = 1; k <= 3; k++) begin
      expect_ev(312 + 8 * k, 199, 1, 0, 0);
      frame();
    end
    hit_now(336, 199);
    right_direction = 1'b0;
    cooldown_fire();
    fire_pulse();
    expect_ev(312, 199, 1, 1, 0);
    frame();
    hit_now(312, 199);
    cooldown_fire();

    // Collision coinciding with startOfFrame: no move, hit wins
    up_direction = 1'b1;
    tick();
    up_direction = 1'b0;
    fire_pulse();
    expect_ev(294, 181, 1, 1, 0);
    frame();
    expect_ev(294, 181, 0, 0, 1);
    startOfFrame = 1'b1;
    collision = 1'b1;
    tick();
    startOfFrame = 1'b0;
    collision = 1'b0;
    tick();
    cooldown_fire();

    // Off-frame spawn is suppressed and the request is consumed
    tankTopLeftY = 11'd2;
    fire_pulse();
    frame();
    chk("suppress_active", bulletActive, 0);
    tankTopLeftY = 11'd185;
    frame();
    chk("suppress_no_retry", bulletActive, 0);
    fire_pulse();
    expect_ev(294, 181, 1, 1, 0);
    frame();
    hit_now(294, 181);
    cooldown_fire();

    // Two keys together hold the previous facing (LEFT)
    left_direction = 1'b1;
    tick();
    left_direction = 1'b0;
    up_direction = 1'b1;
    right_direction = 1'b1;
    repeat (2) tick();
    fire_pulse();
    expect_ev(276, 199, 1, 1, 0);
    frame();
    up_direction = 1'b0;
    right_direction = 1'b0;
    expect_ev(268, 199, 1, 0, 0);
    frame();

    // Asynchronous reset mid-flight
    expect_ev(0, 0, 0, 0, 0);
    #2 resetN = 1'b0;
    #1;
    chk("async_rst_active", bulletActive, 0);
    chk("async_rst_x", bulletTopLeftX, 0);
    tick();
    resetN = 1'b1;
    tick();
    fire_pulse();
    expect_ev(294, 181, 1, 1, 0);
    frame();
    hit_now(294, 181);

    repeat (5) tick();
    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
